// File: rtl/compare_arbiter.sv
// compare_arbiter: round-robin arbiter feeding a single unsigned comparator.
// One request in flight at a time; results are held until the consumer takes them.
module compare_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH-1:0]     req_a,
    input  logic [NREQ*WIDTH-1:0]     req_b,
    output logic [NREQ-1:0]           req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic                      rsp_eq,
    output logic                      rsp_gt,
    output logic                      rsp_lt,
    output logic                      busy,
    output logic [7:0]                eq_count
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   lat_id;
    logic [WIDTH-1:0] lat_a;
    logic [WIDTH-1:0] lat_b;
    logic             found;
    logic [IDW-1:0]   win;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic             take;
    logic             deliver;
    logic [IDW-1:0]   ptr_next;

    // Cyclic search for the first valid requester at or after rr_ptr.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
        a_sel = req_a[int'(win)*WIDTH +: WIDTH];
        b_sel = req_b[int'(win)*WIDTH +: WIDTH];
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_n   = state;
        req_ready = '0;
        take      = 1'b0;
        deliver   = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (found && !rst) begin
                    req_ready[win] = 1'b1;
                    take           = 1'b1;
                    state_n        = CMP;
                end
            end
            CMP: begin
                state_n = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    deliver = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign ptr_next = (lat_id == IDW'(NREQ - 1)) ? '0 : lat_id + IDW'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Operand capture, comparison, pointer advance and eq counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            lat_id   <= '0;
            lat_a    <= '0;
            lat_b    <= '0;
            rsp_id   <= '0;
            rsp_eq   <= 1'b0;
            rsp_gt   <= 1'b0;
            rsp_lt   <= 1'b0;
            eq_count <= '0;
        end else begin
            if (take) begin
                lat_a  <= a_sel;
                lat_b  <= b_sel;
                lat_id <= win;
            end
            if (state == CMP) begin
                rsp_id <= lat_id;
                rsp_eq <= (lat_a == lat_b);
                rsp_gt <= (lat_a > lat_b);
                rsp_lt <= (lat_a < lat_b);
            end
            if (deliver) begin
                rr_ptr <= ptr_next;
                if (rsp_eq && eq_count != 8'hFF) begin
                    eq_count <= eq_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_compare_arbiter.sv
// tb_compare_arbiter: directed vectors for compare_arbiter.
// Expected values are hand-computed per scenario.
module tb_compare_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req_valid;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [3:0] req_ready;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_id;
    logic       rsp_eq;
    logic       rsp_gt;
    logic       rsp_lt;
    logic       busy;
    logic [7:0] eq_count;

    int checks = 0;
    int errors = 0;

    compare_arbiter #(.NREQ(4), .WIDTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_eq    (rsp_eq),
        .rsp_gt    (rsp_gt),
        .rsp_lt    (rsp_lt),
        .busy      (busy),
        .eq_count  (eq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [1:0] a,
                          input logic [1:0] b);
        req_a[i*2 +: 2] = a;
        req_b[i*2 +: 2] = b;
    endtask

    // Full transaction from an IDLE cycle with rsp_ready held high.
    task automatic xact(input string tag, input int id, input logic e,
                        input logic g, input logic l);
        #1;
        chk({tag, "_rdy"}, req_ready, 32'(1 << id));
        tick();
        chk({tag, "_cmp_busy"}, busy, 1);
        chk({tag, "_cmp_vld"}, rsp_valid, 0);
        chk({tag, "_cmp_rdy"}, req_ready, 0);
        tick();
        chk({tag, "_vld"}, rsp_valid, 1);
        chk({tag, "_id"}, rsp_id, id);
        chk({tag, "_flags"}, {rsp_eq, rsp_gt, rsp_lt}, {e, g, l});
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        chk("rst_vld", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_eqc", eq_count, 0);
        chk("rst_rdy", req_ready, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_flags", {rsp_eq, rsp_gt, rsp_lt}, 0);
        req_valid = 4'b0001;
        #1;
        chk("rst_rdy_held", req_ready, 0);

        // Single request: 3 vs 2 -> gt
        rst = 1'b0;
        set_op(0, 2'd3, 2'd2);
        xact("single", 0, 0, 1, 0);
        req_valid = '0;

        // Contention, all four requesters held
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_op(0, 2'd2, 2'd3);
        set_op(1, 2'd2, 2'd2);
        set_op(2, 2'd1, 2'd3);
        set_op(3, 2'd3, 2'd3);
        req_valid = 4'b1111;
        xact("cont0", 0, 0, 0, 1);
        xact("cont1", 1, 1, 0, 0);
        xact("cont2", 2, 0, 0, 1);
        xact("cont3", 3, 1, 0, 0);
        chk("cont_eqc", eq_count, 2);
        xact("cont4", 0, 0, 0, 1);
        chk("cont_eqc5", eq_count, 2);

        // Backpressure on requester 2: 1 vs 0 -> gt
        req_valid = 4'b0100;
        set_op(2, 2'd1, 2'd0);
        rsp_ready = 1'b0;
        #1;
        chk("bp_rdy", req_ready, 4'b0100);
        tick();
        req_valid = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld", rsp_valid, 1);
            chk("bp_id", rsp_id, 2);
            chk("bp_flags", {rsp_eq, rsp_gt, rsp_lt}, 3'b010);
            chk("bp_norq", req_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_vld_last", rsp_valid, 1);
        tick();
        chk("bp_idle", busy, 0);
        chk("bp_eqc", eq_count, 2);

        // Wrap: rr_ptr=3, requesters 3 and 0
        req_valid = 4'b1001;
        set_op(3, 2'd3, 2'd3);
        set_op(0, 2'd2, 2'd3);
        xact("wrap3", 3, 1, 0, 0);
        xact("wrap0", 0, 0, 0, 1);
        chk("wrap_eqc", eq_count, 3);

        // Reset while the response is pending
        req_valid = 4'b0001;
        set_op(0, 2'd2, 2'd2);
        #1;
        chk("rr_rdy", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        tick();
        chk("rr_vld", rsp_valid, 1);
        rst = 1'b1;
        tick();
        chk("rr_vld0", rsp_valid, 0);
        chk("rr_busy0", busy, 0);
        chk("rr_eqc0", eq_count, 0);
        chk("rr_eq0", rsp_eq, 0);
        rst = 1'b0;
        req_valid = 4'b0110;
        set_op(1, 2'd0, 2'd1);
        xact("rr_next", 1, 0, 0, 1);
        chk("rr_eqc", eq_count, 0);

        // Saturation: 260 equal results on requester 0
        rst = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
        req_valid = 4'b0001;
        set_op(0, 2'd1, 2'd1);
        for (int i = 0; i < 260; i++) begin
            xact("sat", 0, 1, 0, 0);
            if (i == 253) chk("sat_254", eq_count, 254);
            if (i == 254) chk("sat_255", eq_count, 255);
        end
        chk("sat_hold", eq_count, 255);
        req_valid = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
